// File: rtl/nand_gate_primitive.sv
// Bitwise NAND cell with a zero-latency combinational output, plus a registered copy (1 cycle)
// with change pulse and saturating toggle counter; no handshake, never stalls.
module nand_gate_primitive #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out_q,
   output logic             out_changed,
   output logic [CNT_W-1:0] toggle_cnt
);

   logic changing;

   // 4-state & already gives nand-primitive X semantics: any 0 operand forces a 1.
   assign out      = ~(in1 & in2);
   assign changing = (out != out_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '1;
         out_changed <= 1'b0;
         toggle_cnt  <= '0;
      end else begin
         out_q       <= out;
         out_changed <= changing;
         if (changing && (toggle_cnt != '1))
            toggle_cnt <= toggle_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_nand_gate_primitive.sv
// Randomized + directed bench: stimulus pushes expected registered state, a monitor pops and checks after each edge.
module tb_nand_gate_primitive;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in1_8, in2_8, out_8, out_q_8;
   logic        ch_8;
   logic [15:0] cnt_8;
   logic        in1_1, in2_1, out_1, out_q_1;
   logic        ch_1;
   logic [1:0]  cnt_1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] q8;
      logic       ch8;
      int         cnt8;
      logic       q1;
      logic       ch1;
      int         cnt1;
   } exp_t;

   exp_t exp_q[$];

   // reference state: the value the registered output should hold, and how many changes it has seen
   logic [7:0] m_q8;
   int         m_cnt8;
   logic       m_q1;
   int         m_cnt1;

   nand_gate_primitive #(.WIDTH(8), .CNT_W(16)) u8 (
      .clk(clk), .rst(rst), .out(out_8), .in1(in1_8), .in2(in2_8),
      .out_q(out_q_8), .out_changed(ch_8), .toggle_cnt(cnt_8)
   );

   nand_gate_primitive #(.WIDTH(1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .out(out_1), .in1(in1_1), .in2(in2_1),
      .out_q(out_q_1), .out_changed(ch_1), .toggle_cnt(cnt_1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Truth-table semantics written out per lane rather than as a vector expression.
   function automatic logic nand_bit(input logic a, input logic b);
      if (a === 1'b0 || b === 1'b0) return 1'b1;
      if (a === 1'b1 && b === 1'b1) return 1'b0;
      return 1'bx;
   endfunction

   function automatic logic [7:0] nand8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = nand_bit(a[i], b[i]);
      return r;
   endfunction

   // Drive one cycle's inputs (called just after a negedge), check the combinational
   // outputs, predict the registered state after the coming edge, then wait a cycle.
   task automatic step(input logic r, input logic [7:0] a8, input logic [7:0] b8,
                       input logic a1, input logic b1);
      exp_t       e;
      logic [7:0] n8;
      logic       n1;
      rst = r; in1_8 = a8; in2_8 = b8; in1_1 = a1; in2_1 = b1;
      #1;
      n8 = nand8(a8, b8);
      n1 = nand_bit(a1, b1);
      chk("out8_comb", 64'(out_8), 64'(n8));
      chk("out1_comb", 64'(out_1), 64'(n1));
      if (r) begin
         m_q8 = 8'hFF; m_cnt8 = 0; e.ch8 = 1'b0;
         m_q1 = 1'b1;  m_cnt1 = 0; e.ch1 = 1'b0;
      end else begin
         e.ch8 = (n8 != m_q8);
         e.ch1 = (n1 != m_q1);
         if (e.ch8) m_cnt8 = (m_cnt8 + 1 > 65535) ? 65535 : m_cnt8 + 1;
         if (e.ch1) m_cnt1 = (m_cnt1 + 1 > 3) ? 3 : m_cnt1 + 1;
         m_q8 = n8;
         m_q1 = n1;
      end
      e.q8 = m_q8; e.cnt8 = m_cnt8; e.q1 = m_q1; e.cnt1 = m_cnt1;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every edge presents new registered outputs; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_q8",   64'(out_q_8), 64'(e.q8));
            chk("changed8", 64'(ch_8),    64'(e.ch8));
            chk("cnt8",     64'(cnt_8),   64'(e.cnt8));
            chk("out_q1",   64'(out_q_1), 64'(e.q1));
            chk("changed1", 64'(ch_1),    64'(e.ch1));
            chk("cnt1",     64'(cnt_1),   64'(e.cnt1));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] xin;
      rst = 1'b1; in1_8 = '0; in2_8 = '0; in1_1 = 1'b0; in2_1 = 1'b0;
      m_q8 = 8'hFF; m_cnt8 = 0; m_q1 = 1'b1; m_cnt1 = 0;
      @(negedge clk);

      // reset state, with the WIDTH=1 truth table walked while reset is held
      step(1, 8'h00, 8'h00, 1'b0, 1'b0);
      step(1, 8'h00, 8'hFF, 1'b0, 1'b1);
      step(1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      step(1, 8'h0F, 8'hFF, 1'b0, 1'b1);
      step(1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      step(1, 8'hAA, 8'h00, 1'b1, 1'b0);

      // first edge after reset produces a change; holding inputs gives none
      step(0, 8'h01, 8'h01, 1'b1, 1'b1);
      step(0, 8'h01, 8'h01, 1'b1, 1'b1);

      // toggle lane 0 on every edge; the 2-bit counter saturates meanwhile
      for (int i = 0; i < 10; i++)
         step(0, (i % 2 == 0) ? 8'h00 : 8'h01, 8'h01, (i % 2 == 0) ? 1'b0 : 1'b1, 1'b1);

      // reset mid-operation, then the multi-lane pattern from the reset value
      step(1, 8'h01, 8'h01, 1'b1, 1'b1);
      step(0, 8'hF0, 8'hCC, 1'b1, 1'b1);
      step(0, 8'hF0, 8'hCC, 1'b1, 1'b1);

      // glitch between edges is visible on out only
      rst = 1'b0; in1_8 = 8'hFF; in2_8 = 8'hFF; in1_1 = 1'b1; in2_1 = 1'b1;
      #1;
      chk("glitch_out8", 64'(out_8), 64'h00);
      chk("glitch_out1", 64'(out_1), 64'h0);
      step(0, 8'hF0, 8'hCC, 1'b1, 1'b1);

      // unknown operand against a 0 still yields 1
      xin = 8'hxx;
      step(0, 8'h00, xin, 1'b0, 1'bx);

      // randomized traffic with occasional reset
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 19) == 0), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom));

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nand_gate_primitive.md
Name: nand_gate_primitive

Overview:
- Two-input NAND cell with a zero-latency combinational output and a registered companion output.
- Adds change tracking on the registered output: a one-cycle change pulse and a saturating toggle counter.
- Used as the basic gate leaf in the basic-gates library. Benches observe `out` directly and use `out_q`/`toggle_cnt` for activity checks.

Parameters:
- WIDTH, 1: number of independent NAND lanes (bitwise operation, lane i uses in1[i], in2[i]).
- CNT_W, 16: width of the toggle counter.

Ports:
- clk  input  1  clock; all sequential logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- out  output  WIDTH  combinational NAND, ~(in1 & in2).
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_q  output  WIDTH  registered NAND.
- out_changed  output  1  one-cycle pulse when out_q changed value at the last edge.
- toggle_cnt  output  CNT_W  count of edges at which out_q changed value, saturating.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- `out`:
  - Purely combinational, zero latency, independent of clk/rst. Valid during reset.
  - Per lane: 0 only when both inputs are 1, else 1.
  - Unknown-value semantics match a Verilog nand primitive: either input 0 gives 1 regardless of the other; otherwise X/Z gives X.
- `out_q`:
  - At each rising clk edge with rst=0, loads ~(in1 & in2). One-cycle latency relative to `out`.
  - Reset value: all ones (equals NAND of 0,0).
- `out_changed`:
  - Registered. At each edge with rst=0, set to 1 iff the value being loaded into out_q differs from the current out_q in any lane; else 0.
  - Reset value: 0.
- `toggle_cnt`:
  - At each edge with rst=0, increments by 1 when the out_q value changes (same condition as out_changed).
  - Holds at all-ones (2^CNT_W − 1) once reached; no wrap.
  - Reset value: 0.
- Reset mid-operation: on an edge with rst=1, out_q returns to all ones and out_changed/toggle_cnt clear to 0.
  - The reset edge is never counted as a change, even if out_q was previously 0.
  - The first edge after reset compares against the all-ones reset value.
- Input glitches between clock edges affect `out` only; registered outputs sample the value at the edge.
- Multiple lanes changing at one edge count as a single toggle.
- No other state. No handshake. WIDTH ≥ 1, CNT_W ≥ 2.

Test Plan:
1. Truth table (WIDTH=1), combinational:
   - in1=0,in2=0 → out=1
   - in2→1 at t=1 → out=1
   - in1→1 at t=5 → out=0
   - in1→0 at t=10 → out=1
   - in1→1 at t=15 → out=0
   - then in2→0 → out=1
2. Registered path: after reset (out_q=1), apply in1=1,in2=1 before an edge.
   - At that edge out_q=0, out_changed=1, toggle_cnt=1.
   - Hold inputs for the next edge: out_q=0, out_changed=0, toggle_cnt=1.
3. Toggle counting: alternate in1 between 1 and 0 with in2=1 on every edge for 10 edges → toggle_cnt=10, out_changed=1 each cycle.
4. Saturation (CNT_W=2): toggle 6 times → toggle_cnt 1,2,3,3,3,3.
5. Reset mid-operation: with out_q=0 and toggle_cnt=5, assert rst for one edge.
   - At that edge: out_q=1, toggle_cnt=0, out_changed=0.
   - out keeps tracking inputs combinationally throughout.
6. Multi-lane (WIDTH=8): in1=8'hF0, in2=8'hCC → out=8'h3F.
   - After the next edge, out_q=8'h3F. From reset value 8'hFF that edge gives out_changed=1 and exactly one counted toggle.
   - X check: in1=0, in2=X → out=1.
